// File: rtl/alu_ctrl_stage_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_stage_if
//   Bundles the issue-side request signals and the registered ID/EX outputs
//   of alu_ctrl_stage. Clock and reset are kept as plain module ports.
//
//   Signals:
//     valid_i    : instr_i carries a real instruction this cycle
//     instr_i    : 32-bit RV32 instruction word
//     stall_i    : hazard-unit freeze of the EX register
//     flush_i    : squash, next EX contents become a bubble
//     ALUCtrl_o  : registered 3-bit ALU op code
//     ALUSrc_o   : registered, 1 = operand B is the immediate
//     valid_o    : registered, EX holds a real instruction
//     illegal_o  : registered, unsupported encoding captured
//     stall_o    : combinational, upstream must hold instr_i/valid_i
//
//   Modports:
//     master : issue logic / testbench side (drives the *_i signals)
//     slave  : alu_ctrl_stage side (drives the *_o signals)
// -----------------------------------------------------------------------------
interface alu_ctrl_stage_if;
  logic        valid_i;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        flush_i;
  logic [2:0]  ALUCtrl_o;
  logic        ALUSrc_o;
  logic        valid_o;
  logic        illegal_o;
  logic        stall_o;

  modport master (
    output valid_i, instr_i, stall_i, flush_i,
    input  ALUCtrl_o, ALUSrc_o, valid_o, illegal_o, stall_o
  );

  modport slave (
    input  valid_i, instr_i, stall_i, flush_i,
    output ALUCtrl_o, ALUSrc_o, valid_o, illegal_o, stall_o
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// alu_ctrl_stage
//   Decodes RV32 opcode/funct3/funct7 into the 3-bit ALU op code and the
//   operand-B source select, and registers both into the ID/EX boundary under
//   valid/stall/flush control. A MUL is held in EX for MUL_LAT cycles, during
//   which stall_o back-pressures the issue logic.
//
//   Parameters:
//     MUL_LAT : cycles a MUL occupies EX, 1..16 (1 = never stalls)
//
//   Ports:
//     clk_i : clock, all state changes on the rising edge
//     rst_i : synchronous reset, active-low
//     bus   : alu_ctrl_stage_if.slave (request inputs, registered outputs)
//
//   Optional feature (macro ALU_CTRL_ILLEGAL_TRAP_EN):
//     defined   : an illegal valid instruction loads as a bubble and pulses
//                 illegal_o for one cycle
//     undefined : an illegal instruction loads as ADD with ALUSrc=0 and
//                 valid_o=1; illegal_o stays 0
// -----------------------------------------------------------------------------
module alu_ctrl_stage #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_ctrl_stage_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SLL = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011,
    OP_XOR = 3'b100,
    OP_SRA = 3'b101,
    OP_AND = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // Four bits cover the whole legal MUL_LAT range (max preset value 15).
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];

  // Register-number and immediate fields play no part in ALU control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr_i[24:15], bus.instr_i[11:7]};

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  alu_op_e dec_op;
  logic    dec_src;
  logic    dec_illegal;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    dec_op      = OP_ADD;
    dec_src     = 1'b0;
    dec_illegal = 1'b1;

    unique case (opcode)
      OPC_REG: begin
        dec_illegal = 1'b0;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: dec_op = OP_ADD;
          {F7_ALT,  3'b000}: dec_op = OP_SUB;
          {F7_MULD, 3'b000}: dec_op = OP_MUL;
          {F7_BASE, 3'b111}: dec_op = OP_AND;
          {F7_BASE, 3'b100}: dec_op = OP_XOR;
          {F7_BASE, 3'b001}: dec_op = OP_SLL;
          {F7_ALT,  3'b101}: dec_op = OP_SRA;
          default:           dec_illegal = 1'b1;
        endcase
      end
      OPC_IMM: begin
        dec_src = 1'b1;
        if (funct3 == 3'b000) begin
          dec_op      = OP_ADD;
          dec_illegal = 1'b0;
        end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
          dec_op      = OP_SRA;
          dec_illegal = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        dec_op      = OP_ADD;
        dec_src     = 1'b1;
        dec_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        dec_op      = OP_SUB;
        dec_illegal = 1'b0;
      end
      default: ;
    endcase

    // An unsupported encoding always presents as ADD with register operand B,
    // which is both the non-trapping load value and the trapping bubble value.
    if (dec_illegal) begin
      dec_op  = OP_ADD;
      dec_src = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-time values of valid_o / illegal_o
  // ---------------------------------------------------------------------------
  logic load_valid;
  logic load_illegal;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign load_valid   = bus.valid_i & ~dec_illegal;
  assign load_illegal = bus.valid_i &  dec_illegal;
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
  assign load_valid         = bus.valid_i;
  assign load_illegal       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // ID/EX register and MUL occupancy counter
  // ---------------------------------------------------------------------------
  alu_op_e    ctrl_q;
  logic       src_q;
  logic       valid_q;
  logic       illegal_q;
  logic [3:0] cnt_q;
  logic       busy;

  assign busy = (cnt_q != 4'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q    <= OP_ADD;
      src_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else if (bus.flush_i) begin
      ctrl_q    <= OP_ADD;
      src_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else if (bus.stall_i || busy) begin
      // Hold EX contents; the MUL countdown keeps running even under an
      // external stall so a frozen pipe does not extend MUL occupancy.
      illegal_q <= 1'b0;
      if (busy) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else begin
      ctrl_q    <= dec_op;
      src_q     <= dec_src;
      valid_q   <= load_valid;
      illegal_q <= load_illegal;
      cnt_q     <= (load_valid && dec_op == OP_MUL) ? CNT_LOAD : 4'd0;
    end
  end

  assign bus.ALUCtrl_o = ctrl_q;
  assign bus.ALUSrc_o  = src_q;
  assign bus.valid_o   = valid_q;
  assign bus.illegal_o = illegal_q;
  assign bus.stall_o   = busy;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_stage
//   Directed bench for alu_ctrl_stage. Two instances share clock and reset:
//   dut3 with MUL_LAT=3 carries most of the stimulus, dut1 with MUL_LAT=1
//   covers the no-stall MUL case. Inputs change 1 time unit after the rising
//   edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_stage;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  alu_ctrl_stage_if bus3 ();
  alu_ctrl_stage_if bus1 ();

  alu_ctrl_stage #(.MUL_LAT(3)) dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus3));
  alu_ctrl_stage #(.MUL_LAT(1)) dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  // Instruction encodings
  logic [31:0] i_add, i_sub, i_sll, i_xor, i_sra, i_and, i_mul;
  logic [31:0] i_addi, i_srai, i_lw, i_sw, i_beq, i_bad;

  // Op sweep stimulus and hand-computed expectations
  logic [31:0] sweep_instr [10];
  logic [2:0]  sweep_ctrl  [10];
  logic        sweep_src   [10];

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_add  = enc(7'b0000000, 3'b000, 7'b0110011);
    i_sub  = enc(7'b0100000, 3'b000, 7'b0110011);
    i_sll  = enc(7'b0000000, 3'b001, 7'b0110011);
    i_xor  = enc(7'b0000000, 3'b100, 7'b0110011);
    i_sra  = enc(7'b0100000, 3'b101, 7'b0110011);
    i_and  = enc(7'b0000000, 3'b111, 7'b0110011);
    i_mul  = enc(7'b0000001, 3'b000, 7'b0110011);
    i_addi = enc(7'b0000000, 3'b000, 7'b0010011);
    i_srai = enc(7'b0100000, 3'b101, 7'b0010011);
    i_lw   = enc(7'b0000000, 3'b010, 7'b0000011);
    i_sw   = enc(7'b0000000, 3'b010, 7'b0100011);
    i_beq  = enc(7'b0000000, 3'b000, 7'b1100011);
    i_bad  = 32'hFFFF_FFFF;

    sweep_instr = '{i_sub, i_sll, i_xor, i_sra, i_and, i_addi, i_srai, i_lw, i_sw, i_beq};
    sweep_ctrl  = '{3'b010, 3'b001, 3'b100, 3'b101, 3'b111,
                    3'b000, 3'b101, 3'b000, 3'b000, 3'b010};
    sweep_src   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // ---------------- Reset ----------------
    rst_i        = 1'b0;
    bus3.valid_i = 1'b1;
    bus3.instr_i = i_add;
    bus3.stall_i = 1'b0;
    bus3.flush_i = 1'b0;
    bus1.valid_i = 1'b0;
    bus1.instr_i = i_add;
    bus1.stall_i = 1'b0;
    bus1.flush_i = 1'b0;
    step();
    step();
    check("rst_ctrl",    32'(bus3.ALUCtrl_o), 32'd0);
    check("rst_src",     32'(bus3.ALUSrc_o),  32'd0);
    check("rst_valid",   32'(bus3.valid_o),   32'd0);
    check("rst_illegal", 32'(bus3.illegal_o), 32'd0);
    check("rst_stall",   32'(bus3.stall_o),   32'd0);
    check("rst_valid1",  32'(bus1.valid_o),   32'd0);

    rst_i = 1'b1;
    step();
    check("post_rst_ctrl",  32'(bus3.ALUCtrl_o), 32'b000);
    check("post_rst_valid", 32'(bus3.valid_o),   32'd1);

    // ---------------- Op sweep ----------------
    for (int i = 0; i < 10; i++) begin
      bus3.instr_i = sweep_instr[i];
      step();
      check($sformatf("sweep%0d_ctrl", i), 32'(bus3.ALUCtrl_o), 32'(sweep_ctrl[i]));
      check($sformatf("sweep%0d_src", i),  32'(bus3.ALUSrc_o),  32'(sweep_src[i]));
      check($sformatf("sweep%0d_valid", i), 32'(bus3.valid_o),  32'd1);
    end

    // ---------------- Bubble ----------------
    bus3.valid_i = 1'b0;
    step();
    check("bubble_valid", 32'(bus3.valid_o), 32'd0);
    check("bubble_stall", 32'(bus3.stall_o), 32'd0);

    // ---------------- MUL, MUL_LAT=3 ----------------
    bus3.valid_i = 1'b1;
    bus3.instr_i = i_mul;
    step();
    check("mul3_c1_ctrl",  32'(bus3.ALUCtrl_o), 32'b011);
    check("mul3_c1_stall", 32'(bus3.stall_o),   32'd1);
    bus3.instr_i = i_add;
    step();
    check("mul3_c2_ctrl",  32'(bus3.ALUCtrl_o), 32'b011);
    check("mul3_c2_stall", 32'(bus3.stall_o),   32'd1);
    step();
    check("mul3_c3_ctrl",  32'(bus3.ALUCtrl_o), 32'b011);
    check("mul3_c3_valid", 32'(bus3.valid_o),   32'd1);
    check("mul3_c3_stall", 32'(bus3.stall_o),   32'd0);
    step();
    check("mul3_c4_ctrl",  32'(bus3.ALUCtrl_o), 32'b000);
    check("mul3_c4_valid", 32'(bus3.valid_o),   32'd1);

    // ---------------- MUL, MUL_LAT=1 ----------------
    bus3.valid_i = 1'b0;
    bus1.valid_i = 1'b1;
    bus1.instr_i = i_mul;
    step();
    check("mul1_ctrl",  32'(bus1.ALUCtrl_o), 32'b011);
    check("mul1_stall", 32'(bus1.stall_o),   32'd0);
    bus1.instr_i = i_add;
    step();
    check("mul1_next_ctrl",  32'(bus1.ALUCtrl_o), 32'b000);
    check("mul1_next_valid", 32'(bus1.valid_o),   32'd1);
    bus1.valid_i = 1'b0;

    // ---------------- Flush mid-MUL ----------------
    bus3.valid_i = 1'b1;
    bus3.instr_i = i_mul;
    step();
    bus3.instr_i = i_xor;
    step();
    check("fmul_c2_ctrl",  32'(bus3.ALUCtrl_o), 32'b011);
    check("fmul_c2_stall", 32'(bus3.stall_o),   32'd1);
    bus3.flush_i = 1'b1;
    step();
    check("fmul_valid", 32'(bus3.valid_o), 32'd0);
    check("fmul_stall", 32'(bus3.stall_o), 32'd0);
    bus3.flush_i = 1'b0;
    step();
    check("fmul_next_ctrl",  32'(bus3.ALUCtrl_o), 32'b100);
    check("fmul_next_valid", 32'(bus3.valid_o),   32'd1);

    // ---------------- stall_i hold, then stall+flush ----------------
    bus3.stall_i = 1'b1;
    bus3.instr_i = i_sub;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("hold%0d_ctrl", k),  32'(bus3.ALUCtrl_o), 32'b100);
      check($sformatf("hold%0d_valid", k), 32'(bus3.valid_o),   32'd1);
    end
    bus3.flush_i = 1'b1;
    step();
    check("stall_flush_valid", 32'(bus3.valid_o), 32'd0);
    bus3.flush_i = 1'b0;
    bus3.stall_i = 1'b0;

    // ---------------- Illegal encoding ----------------
    bus3.valid_i = 1'b1;
    bus3.instr_i = i_bad;
    step();
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    check("ill_valid",   32'(bus3.valid_o),   32'd0);
    check("ill_illegal", 32'(bus3.illegal_o), 32'd1);
    check("ill_ctrl",    32'(bus3.ALUCtrl_o), 32'b000);
`else
    check("ill_valid",   32'(bus3.valid_o),   32'd1);
    check("ill_illegal", 32'(bus3.illegal_o), 32'd0);
    check("ill_ctrl",    32'(bus3.ALUCtrl_o), 32'b000);
    check("ill_src",     32'(bus3.ALUSrc_o),  32'd0);
`endif
    bus3.valid_i = 1'b0;
    step();
    check("ill_clear", 32'(bus3.illegal_o), 32'd0);
    check("ill_after_valid", 32'(bus3.valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
